uart_rx_core: RTL and testbench

//  Receive-side framing engine of the UART. Consumes the oversampling tick

---
 rtl/uart_rx_core_if.sv | 27 ++
 rtl/uart_rx_core.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Received-byte stream of the UART receiver: data, per-byte error flags and valid/ready handshake.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_core_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive framing engine: synchronises rx, validates the start bit, shifts data LSB-first,
// checks optional parity and the stop bit, and presents each byte on a valid/ready stream.
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_tick,
    input  logic             rx,
    input  logic             parity_en,
    input  logic             parity_odd,
    uart_rx_core_if.master   rx_if,
    output logic             overrun,
    output logic             busy
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic                 deliver;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;
    logic                 accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_d     = perr_q;
        deliver    = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                        par_en_d   = parity_en;
                        par_odd_d  = parity_odd;
                        perr_d     = 1'b0;
                    end
                end
                StStart: begin
                    // Mid-bit re-check rejects line glitches shorter than half a bit.
                    if (tick_cnt_q == TickHalf) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tick_cnt_q == TickLast) begin
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == BitLast) begin
                            state_d = par_en_q ? StParity : StStop;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StParity: begin
                    if (tick_cnt_q == TickLast) begin
                        perr_d     = (^{shift_q, rx_s_q}) ^ par_odd_q;
                        tick_cnt_d = '0;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StStop: begin
                    if (tick_cnt_q == TickLast) begin
                        deliver    = 1'b1;
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign accept = valid_q & rx_if.rx_ready;

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = overrun_q;
        if (deliver && (!valid_q || rx_if.rx_ready)) begin
            data_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ~rx_s_q;
            valid_d    = 1'b1;
            if (accept) begin
                overrun_d = 1'b0;
            end
        end else if (deliver) begin
            // Consumer still holds the previous byte: drop this frame.
            overrun_d = 1'b1;
        end else if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_out_q;
    assign rx_if.frame_err  = ferr_out_q;
    assign overrun          = overrun_q;
    assign busy             = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: drives serial frames bit-by-bit and compares the delivered
// stream against frames predicted from the UART framing rules.
module tb_uart_rx_core;
    localparam int unsigned DataBits   = 8;
    localparam int unsigned Oversample = 16;
    localparam int unsigned TickDiv    = 4;
    localparam int unsigned BitClks    = Oversample * TickDiv;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic baud_tick  = 1'b0;
    logic rx         = 1'b1;
    logic parity_en  = 1'b0;
    logic parity_odd = 1'b0;
    logic overrun;
    logic busy;

    uart_rx_core_if #(.DATA_BITS(DataBits)) rx_if ();

    uart_rx_core #(
        .DATA_BITS (DataBits),
        .OVERSAMPLE(Oversample)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .rx_if     (rx_if),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned div_cnt = 0;
    always @(posedge clk) begin
        #1;
        baud_tick = (div_cnt == TickDiv - 1);
        div_cnt   = (div_cnt + 1) % TickDiv;
    end

    frame_t      exp_q[$];
    frame_t      got_q[$];
    int unsigned vectors      = 0;
    int unsigned miscompares  = 0;
    int unsigned valid_cycles = 0;

    // Handshake completes at the next rising edge when valid & ready hold at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_if.rx_valid) valid_cycles++;
            if (rx_if.rx_valid && rx_if.rx_ready)
                got_q.push_back({rx_if.rx_data, rx_if.parity_err, rx_if.frame_err});
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BitClks) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Config is flipped after the start bit to show that the receiver uses the value at frame start.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input bit expect_it);
        logic   pe, po;
        frame_t f;
        pe = parity_en;
        po = parity_odd;
        drive_bit(1'b0);
        parity_en  = ~pe;
        parity_odd = ~po;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(stop);
        rx         = 1'b1;
        parity_en  = pe;
        parity_odd = po;
        if (expect_it) begin
            f.data = d;
            // Even parity wants an even count of ones over data+parity, odd wants an odd count.
            f.perr = pe ? (($countones(d) + int'(pbit)) % 2 != (po ? 1 : 0)) : 1'b0;
            f.ferr = ~stop;
            exp_q.push_back(f);
        end
    endtask

    task automatic wait_frames(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * BitClks; i++) begin
            if (got_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (rx_if.rx_data !== 8'h00) begin
            miscompares++; $display("FAIL reset rx_data: got %h want 00", rx_if.rx_data);
        end
        vectors++;
        if (rx_if.rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset rx_valid: got %b want 0", rx_if.rx_valid);
        end
        vectors++;
        if (rx_if.parity_err !== 1'b0) begin
            miscompares++; $display("FAIL reset parity_err: got %b want 0", rx_if.parity_err);
        end
        vectors++;
        if (rx_if.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset frame_err: got %b want 0", rx_if.frame_err);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++; $display("FAIL reset overrun: got %b want 0", overrun);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL reset busy: got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8);
    endtask

    task automatic test_8n1;
        int unsigned vc0;
        bit          ok;
        frame_t      g, e;
        got_q.delete(); exp_q.delete();
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        idle(BitClks);
        wait_frames(ok);
        vectors++;
        if (!ok || got_q.size() != 1) begin
            miscompares++; $display("FAIL 8n1 count: got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL 8n1 frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        vectors++;
        if (valid_cycles - vc0 != 1) begin
            miscompares++; $display("FAIL 8n1 valid width: got %0d want 1", valid_cycles - vc0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL 8n1 busy after frame: got %b want 0", busy);
        end
    endtask

    task automatic test_parity;
        bit     ok;
        frame_t g, e;
        got_q.delete(); exp_q.delete();
        parity_en = 1'b1;
        for (int m = 0; m < 4; m++) begin
            parity_odd = m[1];
            send_frame(8'h37, m[0], 1'b1, 1'b1);
        end
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        idle(BitClks);
        wait_frames(ok);
        vectors++;
        if (!ok || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL parity count: got %0d frames want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL parity frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
    endtask

    task automatic test_glitch;
        got_q.delete(); exp_q.delete();
        rx = 1'b0;
        repeat (5 * TickDiv) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL glitch busy during low: got %b want 1", busy);
        end
        idle(BitClks);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL glitch busy after: got %b want 0", busy);
        end
        vectors++;
        if (got_q.size() != 0 || rx_if.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch delivery: got %0d frames valid=%b want 0 frames valid=0",
                     got_q.size(), rx_if.rx_valid);
        end
    endtask

    task automatic test_frame_err;
        bit     ok;
        frame_t g, e;
        got_q.delete(); exp_q.delete();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(2 * BitClks);
        wait_frames(ok);
        vectors++;
        if (!ok || got_q.size() != 1) begin
            miscompares++; $display("FAIL ferr count: got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL ferr frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL ferr busy after idle: got %b want 0", busy);
        end
    endtask

    task automatic test_overrun;
        frame_t g, e;
        got_q.delete(); exp_q.delete();
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        idle(BitClks / 2);
        @(negedge clk);
        vectors++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11) begin
            miscompares++;
            $display("FAIL overrun held byte: got valid=%b data=%h want valid=1 data=11",
                     rx_if.rx_valid, rx_if.rx_data);
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++; $display("FAIL overrun flag: got %b want 1", overrun);
        end
        @(posedge clk);
        #1;
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (rx_if.rx_valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun accept: got valid=%b overrun=%b want 0/0",
                     rx_if.rx_valid, overrun);
        end
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL overrun count: got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL overrun frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit     ok;
        frame_t g, e;
        got_q.delete(); exp_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || rx_if.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset state: got busy=%b valid=%b want 0/0", busy, rx_if.rx_valid);
        end
        rst = 1'b1;
        idle(BitClks);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        idle(BitClks);
        wait_frames(ok);
        vectors++;
        if (!ok || got_q.size() != 1) begin
            miscompares++; $display("FAIL midreset count: got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL midreset frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++; $display("FAIL midreset overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_random;
        bit     ok;
        frame_t g, e;
        got_q.delete(); exp_q.delete();
        for (int n = 0; n < 16; n++) begin
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            idle($urandom_range(0, 40));
        end
        parity_en = 1'b0;
        idle(BitClks);
        wait_frames(ok);
        vectors++;
        if (!ok || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random count: got %0d frames want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL random frame: got %h/%b/%b want %h/%b/%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        #2;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
